// File: rtl/demux4bit_4_reg.sv
// Registered 1-to-4 nibble distributor with per-channel valid/ready.
// Define DEMUX_AUTO_SEL_EN for round-robin channel selection.
module demux4bit_4_reg #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  input  logic             S0,
  input  logic             S1,
  output logic [WIDTH-1:0] D0,
  output logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] D2,
  output logic [WIDTH-1:0] D3,
  output logic             V0,
  output logic             V1,
  output logic             V2,
  output logic             V3,
  input  logic             R0,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3
);

  logic [1:0]       sel;
  logic [3:0]       v;
  logic [3:0]       r;
  logic [3:0]       load;
  logic [3:0]       consume;
  logic             accept;
  logic [WIDTH-1:0] d [4];

  assign r = {R3, R2, R1, R0};

`ifdef DEMUX_AUTO_SEL_EN
  logic [1:0] ptr;
  logic       sel_unused;

  assign sel_unused = S0 ^ S1;
  assign sel        = ptr;

  // Pointer advances only on accepted transfers, wrapping 3 -> 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr <= 2'd0;
    end else if (accept) begin
      ptr <= ptr + 2'd1;
    end
  end
`else
  assign sel = {S1, S0};
`endif

  assign Din_ready = ~v[sel] | r[sel];
  assign accept    = Din_valid & Din_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) begin
      load[sel] = 1'b1;
    end
  end

  assign consume = v & r;

  // A load on the same edge as a consume keeps the channel valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        d[k] <= '0;
      end
    end else begin
      v <= load | (v & ~consume);
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          d[k] <= Din;
        end
      end
    end
  end

  assign D0 = d[0];
  assign D1 = d[1];
  assign D2 = d[2];
  assign D3 = d[3];
  assign V0 = v[0];
  assign V1 = v[1];
  assign V2 = v[2];
  assign V3 = v[3];

endmodule

// File: tb/tb_demux4bit_4_reg.sv
// Scoreboard bench for demux4bit_4_reg.
// Per-channel queues hold expected nibbles until consumed.
module tb_demux4bit_4_reg;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] Din;
  logic       Din_valid;
  logic       Din_ready;
  logic       S0, S1;
  logic [3:0] D0, D1, D2, D3;
  logic       V0, V1, V2, V3;
  logic       R0, R1, R2, R3;

  always #5 CLK = ~CLK;

  demux4bit_4_reg #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .Din(Din), .Din_valid(Din_valid), .Din_ready(Din_ready),
    .S0(S0), .S1(S1),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .V0(V0), .V1(V1), .V2(V2), .V3(V3),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] mv;
  logic [3:0] md [4];
  logic [1:0] mptr;
  logic [3:0] q [4][$];

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] dout(input int k);
    case (k)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  task automatic model_reset();
    mv   = 4'b0000;
    mptr = 2'd0;
    for (int k = 0; k < 4; k++) begin
      md[k] = 4'h0;
      q[k].delete();
    end
  endtask

  task automatic check_state();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("D%0d", k), {4'h0, dout(k)}, {4'h0, md[k]});
    end
    check("V", {4'h0, V3, V2, V1, V0}, {4'h0, mv});
  endtask

  task automatic step(input logic       vld,
                      input logic [3:0] din,
                      input logic [1:0] s,
                      input logic [3:0] r);
    logic [1:0] ch;
    logic       rdy;
    logic       acc;
    logic [3:0] cons;
    logic [3:0] front;
    check_state();
    Din       = din;
    Din_valid = vld;
    {S1, S0}  = s;
    {R3, R2, R1, R0} = r;
    #1;
`ifdef DEMUX_AUTO_SEL_EN
    ch = mptr;
`else
    ch = s;
`endif
    rdy = ~mv[ch] | r[ch];
    check("Din_ready", {7'h0, Din_ready}, {7'h0, rdy});
    acc  = vld & rdy;
    cons = mv & r;
    for (int k = 0; k < 4; k++) begin
      if (cons[k]) begin
        if (q[k].size() == 0) begin
          check($sformatf("underflow%0d", k), 8'h1, 8'h0);
        end else begin
          front = q[k].pop_front();
          check($sformatf("pop D%0d", k), {4'h0, dout(k)}, {4'h0, front});
        end
      end
    end
    @(posedge CLK);
    for (int k = 0; k < 4; k++) begin
      if (acc && ch == 2'(k)) begin
        mv[k] = 1'b1;
        md[k] = din;
        q[k].push_back(din);
      end else if (cons[k]) begin
        mv[k] = 1'b0;
      end
    end
    if (acc) mptr = mptr + 2'd1;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    RST = 1'b1;
    Din = 4'h0;
    Din_valid = 1'b0;
    {S1, S0} = 2'd0;
    {R3, R2, R1, R0} = 4'h0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check("rst V", {4'h0, V3, V2, V1, V0}, 8'h0);
    check("rst D", {D1, D0}, 8'h0);
    RST = 1'b0;
    #1;
    check("rst rdy", {7'h0, Din_ready}, 8'h1);
    @(negedge CLK);

    // Basic steer and stall
    step(1'b1, 4'hA, 2'd2, 4'b0000);
    step(1'b1, 4'h5, 2'd2, 4'b0000);
    step(1'b0, 4'h0, 2'd2, 4'b0000);
    // Stall release: consume and load on the same edge
    step(1'b1, 4'h7, 2'd2, 4'b0100);
    step(1'b0, 4'h0, 2'd2, 4'b0100);
    step(1'b0, 4'h0, 2'd2, 4'b0000);

    // Throughput on channel 1
    step(1'b1, 4'h1, 2'd1, 4'b0010);
    step(1'b1, 4'h2, 2'd1, 4'b0010);
    step(1'b1, 4'h3, 2'd1, 4'b0010);
    step(1'b0, 4'h0, 2'd1, 4'b0010);
    step(1'b0, 4'h0, 2'd1, 4'b0000);

    // Independence and select change while stalled
    step(1'b1, 4'h9, 2'd3, 4'b0000);
    step(1'b1, 4'hC, 2'd0, 4'b0000);
    step(1'b1, 4'h4, 2'd3, 4'b0000);
    step(1'b1, 4'h4, 2'd1, 4'b0000);
    step(1'b0, 4'h0, 2'd0, 4'b1111);
    step(1'b0, 4'h0, 2'd0, 4'b0000);

    // Asynchronous reset mid-cycle with a channel valid
    step(1'b1, 4'h6, 2'd2, 4'b0000);
    check_state();
    Din_valid = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    check("async V", {4'h0, V3, V2, V1, V0}, 8'h0);
    check("async D", {D3, D2}, 8'h0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("post rst rdy", {7'h0, Din_ready}, 8'h1);
    @(negedge CLK);

    // Round-robin sequence (channel 3 in the select build)
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 4'(i), 2'd3, 4'b1111);
    end
    step(1'b0, 4'h0, 2'd3, 4'b0000);
`ifdef DEMUX_AUTO_SEL_EN
    check("rr D0", {4'h0, D0}, 8'h5);
`else
    check("sel D3", {4'h0, D3}, 8'h5);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom),
           2'($urandom), 4'($urandom));
    end
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
